stage_writeback: RTL and testbench
==================================

# stage_writeback

Final pipeline stage of the 16-bit CPU. It accepts a completed instruction from the memory/execute stage and drives the register file's single write port. For 32-bit results (multiply/divide, `R0_en`) it sequences two write beats: the low half goes to the destination register and the high half goes to R0. It also republishes the retired result as the stage-3 forwarding bus used by the fetch/decode stage's hazard muxes and register-file write port.

## Interface

Parameters:
- `DATA_W`, 16, register width; the ALU result is `2*DATA_W`.
- `ADDR_W`, 4, register-address width.
- `R0_ADDR`, 0, register that receives the high half of 32-bit results.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `halt_sys`  in  1  system halt; freezes the stage.
- `in_valid`  in  1  upstream instruction present this cycle.
- `in_reg_wr`  in  1  instruction writes the register file.
- `in_R0_en`  in  1  result is 32-bit; high half is written to R0.
- `in_mem2r`  in  1  low half is taken from `in_mem_data` instead of `in_alu[15:0]`.
- `in_alu`  in  32  ALU result.
- `in_mem_data`  in  16  data-memory read data.
- `in_instr`  in  8  top instruction byte: [7:4] opcode, [3:0] destination r1.
- `busy`  out  1  stall request to upstream; the stage will not accept.
- `wr_en`  out  1  register-file write enable.
- `wr_addr`  out  4  register-file write address.
- `wr_data`  out  16  register-file write data.
- `s3_data`  out  32  last accepted result, {high, low}, for forwarding.
- `s3_instruction`  out  8  last accepted instruction byte.
- `s3_R0_en`  out  1  last accepted instruction's `R0_en`.
- `retired_count`  out  16  number of accepted instructions, wrapping.

## Operation

- State machine: IDLE and HIGH_PEND.
- Accept condition: `in_valid & ~busy & ~halt_sys`, sampled at the clock edge.
- On accept (IDLE):
  - `wr_en <= in_reg_wr`.
  - `wr_addr <= in_instr[3:0]`.
  - `wr_data <= in_mem2r ? in_mem_data : in_alu[15:0]`.
  - Capture `s3_data`, `s3_instruction`, `s3_R0_en`.
  - Increment `retired_count`; it wraps from 0xFFFF to 0x0000.
  - If `in_reg_wr & in_R0_en`: latch `in_alu[31:16]`, go to HIGH_PEND, and set `busy <= 1`.
- The high half always comes from the ALU, even when `in_mem2r=1`.
- HIGH_PEND, on an edge with `~halt_sys`:
  - `wr_en <= 1`, `wr_addr <= R0_ADDR`, `wr_data <=` latched high half.
  - `busy <= 0`, return to IDLE.
- No accept in IDLE: `wr_en <= 0`; all other outputs hold.
- Destination equals `R0_ADDR` with `R0_en`: both beats are issued in order (low, then high), so R0 ends holding the high half.
- Halt: on any edge with `halt_sys=1`:
  - `wr_en <= 0`; state, `busy`, the latched high half, and the `s3_*` outputs hold.
  - A pending high beat completes on the first edge with `halt_sys=0`.
- `in_R0_en` with `in_reg_wr=0`: single beat with `wr_en=0`, no HIGH_PEND; `s3_R0_en` is still captured.

## Timing

- All outputs are registered; nothing is combinational from inputs.
- Latency: accept at edge N; the low write is visible in cycle N..N+1 and is committed by the register file at edge N+1.
- High write is visible in cycle N+1..N+2.
- `busy` is high in cycle N..N+1 only, when no halt intervenes. Upstream must hold its outputs at edge N+1; the next accept can occur at edge N+2.
- Throughput: one 16-bit instruction per cycle; one 32-bit instruction per two cycles.
- Reset values: state IDLE, `busy=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`, `s3_data=0`, `s3_instruction=0`, `s3_R0_en=0`, `retired_count=0`, latched high half 0.
- Reset mid-HIGH_PEND: the pending beat is discarded and `busy` drops immediately (asynchronous).
- `in_valid` while `busy=1`: ignored; no counter change and no capture.

## Test plan

- Reset: assert `rst` mid-cycle → all outputs 0 asynchronously. Release, idle 3 cycles → `wr_en` stays 0 and `retired_count=0`.
- 16-bit write: `in_valid=1`, `in_reg_wr=1`, `in_instr=0x23`, `in_alu=0x0000_1234` → next cycle `wr_en=1`, `wr_addr=3`, `wr_data=0x1234`, `busy=0`, `retired_count=1`. Following idle cycle → `wr_en=0`.
- mem2r: `in_mem2r=1`, `in_mem_data=0xBEEF`, `in_alu=0x0000_1111`, `in_instr=0x85` → `wr_addr=5`, `wr_data=0xBEEF`, `s3_data=0x0000_BEEF`.
- 32-bit write with back-pressure: `in_R0_en=1`, `in_alu=0xABCD_0042`, `in_instr=0x16`, then a second valid instruction presented immediately →
  - cycle 1: `wr_addr=6`, `wr_data=0x0042`, `busy=1`.
  - cycle 2: `wr_addr=0`, `wr_data=0xABCD`, `busy=0`.
  - the second instruction writes in cycle 3.
  - `retired_count=2`.
- Halt in HIGH_PEND: raise `halt_sys` for 3 cycles after the low beat → `wr_en=0`, `busy=1` throughout. Drop halt → R0 write of the high half on the next cycle, then `busy=0`.
- Reset during HIGH_PEND plus counter wrap:
  - preload 0xFFFF retirements, then issue one more → `retired_count=0x0000`.
  - assert `rst` during a pending high beat → no R0 write occurs after release.

Source files
------------

// File: rtl/stage_writeback.sv
// stage_writeback: final pipeline stage driving the register-file write port, sequencing 32-bit results as two beats.
module stage_writeback #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int R0_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt_sys,
  input  logic                  in_valid,
  input  logic                  in_reg_wr,
  input  logic                  in_R0_en,
  input  logic                  in_mem2r,
  input  logic [2*DATA_W-1:0]   in_alu,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic [7:0]            in_instr,
  output logic                  busy,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [2*DATA_W-1:0]   s3_data,
  output logic [7:0]            s3_instruction,
  output logic                  s3_R0_en,
  output logic [15:0]           retired_count
);
  typedef enum logic {IDLE, HIGH_PEND} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] hi_q, hi_n, low, wr_data_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [2*DATA_W-1:0] s3_data_n;
  logic [7:0] s3_instr_n;
  logic [15:0] cnt_n;
  logic wr_en_n, s3_r0_n, accept;
  assign busy = (state == HIGH_PEND);
  assign low = in_mem2r ? in_mem_data : in_alu[DATA_W-1:0];
  assign accept = in_valid & ~busy & ~halt_sys;
  always_comb begin
    state_n    = state;
    hi_n       = hi_q;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    s3_data_n  = s3_data;
    s3_instr_n = s3_instruction;
    s3_r0_n    = s3_R0_en;
    cnt_n      = retired_count;
    if (busy && !halt_sys) begin
      wr_en_n   = 1'b1;
      wr_addr_n = ADDR_W'(R0_ADDR);
      wr_data_n = hi_q;
      state_n   = IDLE;
    end else if (accept) begin
      wr_en_n    = in_reg_wr;
      wr_addr_n  = in_instr[ADDR_W-1:0];
      wr_data_n  = low;
      s3_data_n  = {in_alu[2*DATA_W-1:DATA_W], low};
      s3_instr_n = in_instr;
      s3_r0_n    = in_R0_en;
      cnt_n      = retired_count + 16'd1;
      hi_n       = (in_reg_wr & in_R0_en) ? in_alu[2*DATA_W-1:DATA_W] : hi_q;
      state_n    = (in_reg_wr & in_R0_en) ? HIGH_PEND : IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      hi_q           <= '0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      s3_data        <= '0;
      s3_instruction <= '0;
      s3_R0_en       <= 1'b0;
      retired_count  <= '0;
    end else begin
      state          <= state_n;
      hi_q           <= hi_n;
      wr_en          <= wr_en_n;
      wr_addr        <= wr_addr_n;
      wr_data        <= wr_data_n;
      s3_data        <= s3_data_n;
      s3_instruction <= s3_instr_n;
      s3_R0_en       <= s3_r0_n;
      retired_count  <= cnt_n;
    end
  end
endmodule

// File: tb/tb_stage_writeback.sv
// tb_stage_writeback: directed scenarios plus a randomized run against a queue-based write model.
module tb_stage_writeback;
  logic clk = 0, rst = 1, halt_sys = 0, in_valid = 0, in_reg_wr = 0, in_R0_en = 0, in_mem2r = 0;
  logic [31:0] in_alu = 0;
  logic [15:0] in_mem_data = 0;
  logic [7:0] in_instr = 0;
  logic busy, wr_en;
  logic [3:0] wr_addr;
  logic [15:0] wr_data, retired_count;
  logic [31:0] s3_data;
  logic [7:0] s3_instruction;
  logic s3_R0_en;
  int checks = 0, errors = 0;
  logic [15:0] exp_cnt = 0;

  stage_writeback dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys), .in_valid(in_valid), .in_reg_wr(in_reg_wr),
    .in_R0_en(in_R0_en), .in_mem2r(in_mem2r), .in_alu(in_alu), .in_mem_data(in_mem_data),
    .in_instr(in_instr), .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .s3_data(s3_data), .s3_instruction(s3_instruction), .s3_R0_en(s3_R0_en),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, rw, r0, m2r, input logic [31:0] alu, input logic [15:0] mem, input logic [7:0] ins);
    in_valid = v; in_reg_wr = rw; in_R0_en = r0; in_mem2r = m2r; in_alu = alu; in_mem_data = mem; in_instr = ins;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #12 rst = 0;
    drive(1, 1, 0, 0, 32'hFFFF_FFFF, 0, 8'hFF);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1; #1;
    checks++;
    if ({busy, wr_en, wr_addr, wr_data, s3_data, s3_instruction, s3_R0_en, retired_count} !== '0) begin
      errors++; $display("FAIL async_reset: got busy=%b wr_en=%b addr=%h data=%h s3=%h ins=%h r0=%b cnt=%h want all 0",
        busy, wr_en, wr_addr, wr_data, s3_data, s3_instruction, s3_R0_en, retired_count);
    end
    @(negedge clk) rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (wr_en !== 0 || retired_count !== 0) begin
        errors++; $display("FAIL reset_idle: wr_en=%b cnt=%h want 0/0", wr_en, retired_count);
      end
    end
    exp_cnt = 0;
  endtask

  task automatic test_write16;
    drive(1, 1, 0, 0, 32'h0000_1234, 0, 8'h23);
    tick; exp_cnt++;
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, retired_count} !== {1'b1, 4'h3, 16'h1234, 1'b0, exp_cnt}) begin
      errors++; $display("FAIL write16: got en=%b addr=%h data=%h busy=%b cnt=%h want 1 3 1234 0 %h",
        wr_en, wr_addr, wr_data, busy, retired_count, exp_cnt);
    end
    tick;
    checks++;
    if (wr_en !== 0) begin errors++; $display("FAIL write16_idle: wr_en=%b want 0", wr_en); end
  endtask

  task automatic test_mem2r;
    drive(1, 1, 0, 1, 32'h0000_1111, 16'hBEEF, 8'h85);
    tick; exp_cnt++;
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({wr_en, wr_addr, wr_data, s3_data, s3_instruction} !== {1'b1, 4'h5, 16'hBEEF, 32'h0000_BEEF, 8'h85}) begin
      errors++; $display("FAIL mem2r: got en=%b addr=%h data=%h s3=%h ins=%h want 1 5 beef 0000beef 85",
        wr_en, wr_addr, wr_data, s3_data, s3_instruction);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] c0;
    c0 = exp_cnt;
    drive(1, 1, 1, 0, 32'hABCD_0042, 0, 8'h16);
    tick; exp_cnt++;
    drive(1, 1, 0, 0, 32'h0000_5555, 0, 8'h27);
    checks++;
    if ({wr_en, wr_addr, wr_data, busy} !== {1'b1, 4'h6, 16'h0042, 1'b1}) begin
      errors++; $display("FAIL b2b_low: got en=%b addr=%h data=%h busy=%b want 1 6 0042 1", wr_en, wr_addr, wr_data, busy);
    end
    tick;
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, s3_data, s3_R0_en} !== {1'b1, 4'h0, 16'hABCD, 1'b0, 32'hABCD_0042, 1'b1}) begin
      errors++; $display("FAIL b2b_high: got en=%b addr=%h data=%h busy=%b s3=%h r0=%b want 1 0 abcd 0 abcd0042 1",
        wr_en, wr_addr, wr_data, busy, s3_data, s3_R0_en);
    end
    tick; exp_cnt++;
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({wr_en, wr_addr, wr_data, retired_count} !== {1'b1, 4'h7, 16'h5555, c0 + 16'd2}) begin
      errors++; $display("FAIL b2b_second: got en=%b addr=%h data=%h cnt=%h want 1 7 5555 %h",
        wr_en, wr_addr, wr_data, retired_count, c0 + 16'd2);
    end
  endtask

  task automatic test_halt;
    drive(1, 1, 1, 0, 32'h1357_2468, 0, 8'h19);
    tick; exp_cnt++;
    drive(0, 0, 0, 0, 0, 0, 0);
    halt_sys = 1;
    checks++;
    if ({wr_en, wr_addr, wr_data, busy} !== {1'b1, 4'h9, 16'h2468, 1'b1}) begin
      errors++; $display("FAIL halt_low: got en=%b addr=%h data=%h busy=%b want 1 9 2468 1", wr_en, wr_addr, wr_data, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (wr_en !== 0 || busy !== 1) begin
        errors++; $display("FAIL halt_hold%0d: wr_en=%b busy=%b want 0 1", i, wr_en, busy);
      end
    end
    halt_sys = 0;
    tick;
    checks++;
    if ({wr_en, wr_addr, wr_data, busy} !== {1'b1, 4'h0, 16'h1357, 1'b0}) begin
      errors++; $display("FAIL halt_high: got en=%b addr=%h data=%h busy=%b want 1 0 1357 0", wr_en, wr_addr, wr_data, busy);
    end
    tick;
    checks++;
    if (wr_en !== 0) begin errors++; $display("FAIL halt_after: wr_en=%b want 0", wr_en); end
  endtask

  task automatic test_reset_pending_and_wrap;
    int writes;
    drive(1, 1, 1, 0, 32'h7777_0001, 0, 8'h12);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1; #1;
    checks++;
    if (busy !== 0 || wr_en !== 0) begin
      errors++; $display("FAIL reset_pending: busy=%b wr_en=%b want 0 0", busy, wr_en);
    end
    @(negedge clk) rst = 0;
    writes = 0;
    for (int i = 0; i < 4; i++) begin tick; writes += int'(wr_en); end
    checks++;
    if (writes !== 0) begin errors++; $display("FAIL reset_no_r0: writes=%0d want 0", writes); end
    exp_cnt = 0;
    drive(1, 0, 0, 0, 0, 0, 8'h01);
    repeat (65535) @(posedge clk);
    #1;
    checks++;
    if (retired_count !== 16'hFFFF) begin
      errors++; $display("FAIL preload: cnt=%h want ffff", retired_count);
    end
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (retired_count !== 16'h0000) begin
      errors++; $display("FAIL wrap: cnt=%h want 0000", retired_count);
    end
    exp_cnt = 0;
  endtask

  // Model: a queue of register writes the stage still owes; an instruction is taken only when nothing is owed.
  task automatic test_random;
    logic [19:0] owed[$];
    logic exp_en;
    logic [19:0] exp_wr;
    logic [31:0] exp_s3;
    logic [7:0] exp_ins;
    logic exp_r0;
    logic [15:0] lo;
    exp_s3 = s3_data; exp_ins = s3_instruction; exp_r0 = s3_R0_en; exp_wr = {wr_addr, wr_data};
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom, 16'($urandom), 8'($urandom));
      halt_sys = $urandom_range(0, 4) == 0;
      exp_en = 0;
      if (halt_sys) ;
      else if (owed.size() != 0) begin exp_en = 1; exp_wr = owed.pop_front(); end
      else if (in_valid) begin
        lo = in_mem2r ? in_mem_data : in_alu[15:0];
        exp_en = in_reg_wr; exp_wr = {in_instr[3:0], lo};
        exp_s3 = {in_alu[31:16], lo}; exp_ins = in_instr; exp_r0 = in_R0_en;
        exp_cnt++;
        if (in_reg_wr && in_R0_en) owed.push_back({4'h0, in_alu[31:16]});
      end
      tick;
      checks++;
      if ({wr_en, wr_addr, wr_data, busy, s3_data, s3_instruction, s3_R0_en, retired_count} !==
          {exp_en, exp_wr, owed.size() != 0, exp_s3, exp_ins, exp_r0, exp_cnt}) begin
        errors++; $display("FAIL random%0d: got en=%b addr=%h data=%h busy=%b s3=%h ins=%h r0=%b cnt=%h want en=%b wr=%h busy=%b s3=%h ins=%h r0=%b cnt=%h",
          n, wr_en, wr_addr, wr_data, busy, s3_data, s3_instruction, s3_R0_en, retired_count,
          exp_en, exp_wr, owed.size() != 0, exp_s3, exp_ins, exp_r0, exp_cnt);
      end
    end
    halt_sys = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_write16;
    test_mem2r;
    test_back_to_back;
    test_halt;
    test_reset_pending_and_wrap;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
